// File: rtl/snx_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snx_mem_pkg                                                                |
// | Region constants and encodings shared by the SNX memory arbiter.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package snx_mem_pkg;

    localparam logic [15:0] ROM_BASE     = 16'h0000;
    localparam logic [15:0] RAM_BASE     = 16'h8000;
    localparam int          REGION_WORDS = 1024;
    localparam int          STARVE_LIMIT = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        SEL_IF = 1'b0,
        SEL_D  = 1'b1
    } sel_t;

endpackage
`default_nettype wire

// File: rtl/snx_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snx_mem_arbiter_if                                                         |
// | Requester (fetch/data) and ROM/RAM pin bundle of the memory arbiter.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface snx_mem_arbiter_if;

    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        d_err;

    logic        rom_read;
    logic [15:0] rom_addr;
    logic [15:0] rom_out;
    logic        ram_read;
    logic        ram_write;
    logic [15:0] ram_addr;
    logic [15:0] ram_in;
    logic [15:0] ram_out;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, rom_out, ram_out,
        output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
        output rom_read, rom_addr, ram_read, ram_write, ram_addr, ram_in
    );

    // Requesters and memories side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, rom_out, ram_out,
        input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
        input  rom_read, rom_addr, ram_read, ram_write, ram_addr, ram_in
    );

endinterface
`default_nettype wire

// File: rtl/snx_addr_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snx_addr_decode                                                            |
// | Combinational ROM/RAM region decode with region-relative word offset.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module snx_addr_decode #(
    parameter logic [15:0] ROM_BASE     = snx_mem_pkg::ROM_BASE,
    parameter logic [15:0] RAM_BASE     = snx_mem_pkg::RAM_BASE,
    parameter int          REGION_WORDS = snx_mem_pkg::REGION_WORDS
) (
    input  logic [15:0] addr,
    output logic        rom_hit,
    output logic        ram_hit,
    output logic [15:0] offset
);

    localparam logic [16:0] c_words = 17'(REGION_WORDS);

    logic [15:0] w_rom_off;
    logic [15:0] w_ram_off;

    // 17-bit compare so a region ending at 16'hFFFF still decodes correctly
    always_comb begin
        w_rom_off = addr - ROM_BASE;
        w_ram_off = addr - RAM_BASE;
        rom_hit   = (addr >= ROM_BASE) && ({1'b0, w_rom_off} < c_words);
        ram_hit   = (addr >= RAM_BASE) && ({1'b0, w_ram_off} < c_words);
        if (rom_hit)
            offset = w_rom_off;
        else if (ram_hit)
            offset = w_ram_off;
        else
            offset = 16'h0000;
    end

endmodule
`default_nettype wire

// File: rtl/snx_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | snx_mem_arbiter                                                            |
// | Fetch/data port arbiter with single-cycle ROM/RAM access and ack pulse.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module snx_mem_arbiter #(
    parameter logic [15:0] ROM_BASE     = snx_mem_pkg::ROM_BASE,
    parameter logic [15:0] RAM_BASE     = snx_mem_pkg::RAM_BASE,
    parameter int          REGION_WORDS = snx_mem_pkg::REGION_WORDS,
    parameter int          STARVE_LIMIT = snx_mem_pkg::STARVE_LIMIT
) (
    input  logic             m_clock,
    input  logic             p_reset,
    snx_mem_arbiter_if.slave bus
);
    import snx_mem_pkg::*;

    localparam int                 c_cnt_w = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_starve_cnt;
    logic               r_if_ack, r_if_err, r_d_ack, r_d_err;
    logic [15:0]        r_if_rdata, r_d_rdata;

    sel_t        w_sel;
    logic [15:0] w_addr;
    logic        w_any, w_we, w_grant, w_err;
    logic        w_rom_hit, w_ram_hit;
    logic [15:0] w_offset;
    logic        w_rom_read, w_ram_read, w_ram_write;
    logic [15:0] w_rdata;

    always_comb begin
        w_any = bus.if_req | bus.d_req;
        w_sel = (bus.d_req && (!bus.if_req || (r_starve_cnt != c_limit))) ? SEL_D : SEL_IF;
        w_addr = (w_sel == SEL_D) ? bus.d_addr : bus.if_addr;
        w_we   = (w_sel == SEL_D) & bus.d_we;
    end

    snx_addr_decode #(
        .ROM_BASE     (ROM_BASE),
        .RAM_BASE     (RAM_BASE),
        .REGION_WORDS (REGION_WORDS)
    ) u_decode (
        .addr    (w_addr),
        .rom_hit (w_rom_hit),
        .ram_hit (w_ram_hit),
        .offset  (w_offset)
    );

    // ROM writes are refused; ROM wins if the regions were ever configured to overlap
    always_comb begin
        w_grant     = (r_state == IDLE) & w_any;
        w_rom_read  = w_grant & w_rom_hit & ~w_we;
        w_ram_read  = w_grant & ~w_rom_hit & w_ram_hit & ~w_we;
        w_ram_write = w_grant & ~w_rom_hit & w_ram_hit & w_we;
        w_err       = ~(w_rom_hit | w_ram_hit) | (w_rom_hit & w_we);
        if (w_rom_read)
            w_rdata = bus.rom_out;
        else if (w_ram_read)
            w_rdata = bus.ram_out;
        else
            w_rdata = 16'h0000;
    end

    // Memory pins are combinational and forced low while reset is held
    assign bus.rom_read  = w_rom_read & p_reset;
    assign bus.ram_read  = w_ram_read & p_reset;
    assign bus.ram_write = w_ram_write & p_reset;
    assign bus.rom_addr  = (w_rom_read & p_reset) ? w_offset : 16'h0000;
    assign bus.ram_addr  = ((w_ram_read | w_ram_write) & p_reset) ? w_offset : 16'h0000;
    assign bus.ram_in    = (w_ram_write & p_reset) ? bus.d_wdata : 16'h0000;

    assign bus.if_ack   = r_if_ack;
    assign bus.if_rdata = r_if_rdata;
    assign bus.if_err   = r_if_err;
    assign bus.d_ack    = r_d_ack;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.d_err    = r_d_err;

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_if_ack     <= 1'b0;
            r_if_rdata   <= 16'h0000;
            r_if_err     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_d_rdata    <= 16'h0000;
            r_d_err      <= 1'b0;
        end else begin
            r_if_ack   <= 1'b0;
            r_if_rdata <= 16'h0000;
            r_if_err   <= 1'b0;
            r_d_ack    <= 1'b0;
            r_d_rdata  <= 16'h0000;
            r_d_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= RESP;
                        if (w_sel == SEL_D) begin
                            r_d_ack   <= 1'b1;
                            r_d_rdata <= w_rdata;
                            r_d_err   <= w_err;
                        end else begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= w_rdata;
                            r_if_err   <= w_err;
                        end
                    end
                    if ((w_sel == SEL_D) && w_any && bus.if_req) begin
                        if (r_starve_cnt != c_limit)
                            r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
